// File: rtl/demux_burst_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_burst_scheduler_if
//  Description : Bundle of the source handshake, destination status and demux
//                control signals around demux_burst_scheduler.
//                master : upstream source / demux fabric side
//                slave  : the scheduler itself
//  Signals     : en_mask[7:0]    per-destination enable
//                din[DW-1:0]     source data word
//                din_valid       source has a word
//                din_ready       scheduler accepts din this cycle
//                dst_ready[7:0]  destination i can take a word
//                sel[2:0]        demux select
//                dout[DW-1:0]    steered data word
//                dout_valid[7:0] one-hot write strobe
//                busy            burst in progress
//                burst_done      one-cycle pulse at burst completion
//  Revision    : 1.0 - initial release
// ============================================================================
interface demux_burst_scheduler_if #(
  parameter int DW = 8
);
  logic [7:0]    en_mask;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [7:0]    dst_ready;
  logic [2:0]    sel;
  logic [DW-1:0] dout;
  logic [7:0]    dout_valid;
  logic          busy;
  logic          burst_done;

  modport master (
    output en_mask, din, din_valid, dst_ready,
    input  din_ready, sel, dout, dout_valid, busy, burst_done
  );

  modport slave (
    input  en_mask, din, din_valid, dst_ready,
    output din_ready, sel, dout, dout_valid, busy, burst_done
  );
endinterface
`default_nettype wire

// File: rtl/demux_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : demux_burst_scheduler
//  Description : Sequences a 1-to-8 demux. Accepts a word stream over a
//                valid/ready handshake and steers it to one destination at a
//                time in bursts of BURST words, rotating round-robin over the
//                destinations that are enabled and ready.
//  Ports       : clk            system clock, rising edge
//                rst            synchronous active-high reset
//                bus (slave)    handshake, destination status, demux control
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_burst_scheduler #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  demux_burst_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

  state_t        state_q;
  logic [2:0]    sel_q;
  logic [2:0]    ptr_q;
  logic [3:0]    cnt_q;
  logic [DW-1:0] dout_q;
  logic [7:0]    dout_valid_q;
  logic          busy_q;
  logic          burst_done_q;

  logic [7:0]    cand;
  logic [7:0]    rot;
  logic          found;
  logic [2:0]    off;
  logic [2:0]    pick;
  logic          send_ok;
  logic          xfer;

  // Candidates rotated so that bit 0 corresponds to the pointer position;
  // the lowest set bit of rot is then the first eligible destination at or
  // after ptr.
  assign cand = bus.en_mask & bus.dst_ready;

  always_comb begin
    rot = '0;
    for (int i = 0; i < 8; i++) begin
      rot[i] = cand[3'(ptr_q + 3'(i))];
    end
  end

  always_comb begin
    found = 1'b0;
    off   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = 3'(i);
      end
    end
  end

  assign pick = ptr_q + off;

  // Handshake is only open while a burst is active and the granted
  // destination is both enabled and ready.
  assign send_ok       = bus.dst_ready[sel_q] & bus.en_mask[sel_q];
  assign bus.din_ready = (state_q == ST_SEND) & send_ok;
  assign xfer          = bus.din_valid & bus.din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= 3'd0;
      ptr_q        <= 3'd0;
      cnt_q        <= 4'd0;
      dout_q       <= '0;
      dout_valid_q <= 8'h00;
      busy_q       <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      dout_valid_q <= 8'h00;
      case (state_q)
        ST_IDLE: begin
          if (bus.din_valid && (bus.en_mask != 8'h00)) begin
            state_q <= ST_SEEK;
          end
        end
        ST_SEEK: begin
          // Losing the source or every enable takes priority over a grant.
          if (!bus.din_valid || (bus.en_mask == 8'h00)) begin
            state_q <= ST_IDLE;
          end else if (found) begin
            sel_q   <= pick;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!bus.en_mask[sel_q]) begin
            // Abort: destination disabled mid-burst, no completion pulse.
            ptr_q   <= sel_q + 3'd1;
            busy_q  <= 1'b0;
            state_q <= ST_SEEK;
          end else if (xfer) begin
            dout_q       <= bus.din;
            dout_valid_q <= 8'b1 << sel_q;
            cnt_q        <= cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
              burst_done_q <= 1'b1;
              ptr_q        <= sel_q + 3'd1;
              busy_q       <= 1'b0;
              state_q      <= ST_SEEK;
            end
          end
          // Otherwise stalled: sel, cnt and ptr hold.
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.burst_done = burst_done_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_burst_scheduler
//  Description : Scoreboard bench for demux_burst_scheduler. A tracker pushes
//                the expected destination/data of every accepted word; a
//                monitor pops and compares whenever a strobe appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_burst_scheduler;

  localparam int DW    = 8;
  localparam int BURST = 4;
  localparam int LIMIT = 2000;

  typedef struct {
    int         dst;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;

  demux_burst_scheduler_if #(.DW(DW)) bus ();

  demux_burst_scheduler #(.DW(DW), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks     = 0;
  int         failures   = 0;
  int         acc_cnt    = 0;
  int         plan_start = 0;
  int         bd_cnt     = 0;
  int         plan_w[$];
  exp_t       exp_q[$];
  logic [7:0] strobe_or  = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_burst(input int d, input int n);
    for (int i = 0; i < n; i++) plan_w.push_back(d);
  endtask

  task automatic wait_words(input string name, input int n);
    int t;
    t = 0;
    while ((acc_cnt - plan_start) < n && t < LIMIT) begin
      cyc(1);
      t++;
    end
    checks++;
    if (t >= LIMIT) begin
      failures++;
      $display("FAIL wait_%s accepted=%0d required=%0d", name, acc_cnt - plan_start, n);
    end
  endtask

  // Tracker: records every accepted word with its planned destination and
  // advances din after the edge that consumed it.
  initial begin : tracker
    int   k;
    logic got;
    bus.din = 8'h00;
    forever begin
      @(negedge clk);
      got = 1'b0;
      if (!rst && bus.din_valid && bus.din_ready) begin
        k = acc_cnt - plan_start;
        exp_q.push_back('{dst: (k < plan_w.size()) ? plan_w[k] : 99, data: bus.din});
        acc_cnt++;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      if (got) bus.din = acc_cnt[7:0];
    end
  end

  // Monitor: compares every presented strobe against the scoreboard.
  initial begin : monitor
    exp_t       e;
    logic [7:0] exp_strobe;
    forever begin
      @(negedge clk);
      if (bus.burst_done === 1'b1) bd_cnt++;
      if (bus.dout_valid !== 8'h00) begin
        strobe_or = strobe_or | bus.dout_valid;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {24'h0, bus.dout_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          exp_strobe = (e.dst >= 0 && e.dst < 8) ? (8'b1 << e.dst) : 8'h00;
          chk("dout_valid", {24'h0, bus.dout_valid}, {24'h0, exp_strobe});
          chk("dout", {24'h0, bus.dout}, {24'h0, e.data});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drain(input string name);
    bus.din_valid = 1'b0;
    cyc(4);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    bus.din_valid = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin : stim
    int bd0;

    // ---------------- reset ----------------
    rst           = 1'b1;
    bus.din_valid = 1'b1;
    bus.en_mask   = 8'hFF;
    bus.dst_ready = 8'hFF;
    cyc(2);
    chk("rst_sel", {29'h0, bus.sel}, 32'h0);
    chk("rst_dout_valid", {24'h0, bus.dout_valid}, 32'h0);
    chk("rst_dout", {24'h0, bus.dout}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_burst_done", {31'h0, bus.burst_done}, 32'h0);
    chk("rst_din_ready", {31'h0, bus.din_ready}, 32'h0);

    // ---------------- round robin over all eight ----------------
    plan_w.delete();
    for (int b = 0; b < 9; b++) add_burst(b % 8, BURST);
    plan_start = acc_cnt;
    bd0 = bd_cnt;
    rst = 1'b0;
    cyc(1);
    chk("seek_busy", {31'h0, bus.busy}, 32'h0);
    cyc(1);
    chk("first_grant_busy", {31'h0, bus.busy}, 32'h1);
    chk("first_grant_sel", {29'h0, bus.sel}, 32'h0);
    wait_words("rr", 9 * BURST);
    drain("rr");
    chk("rr_burst_done", bd_cnt - bd0, 9);
    chk("rr_idle_busy", {31'h0, bus.busy}, 32'h0);

    // ---------------- skip disabled destinations ----------------
    pulse_reset();
    plan_w.delete();
    add_burst(0, BURST); add_burst(2, BURST); add_burst(5, BURST);
    add_burst(7, BURST); add_burst(0, BURST);
    plan_start    = acc_cnt;
    bd0           = bd_cnt;
    strobe_or     = 8'h00;
    bus.en_mask   = 8'hA5;
    bus.dst_ready = 8'hFF;
    bus.din_valid = 1'b1;
    wait_words("skip", 5 * BURST);
    drain("skip");
    chk("skip_strobes", {24'h0, strobe_or}, 32'hA5);
    chk("skip_burst_done", bd_cnt - bd0, 5);

    // ---------------- stall mid-burst on d3 ----------------
    pulse_reset();
    plan_w.delete();
    add_burst(3, BURST);
    plan_start    = acc_cnt;
    bd0           = bd_cnt;
    bus.en_mask   = 8'hFF;
    bus.dst_ready = 8'h08;
    bus.din_valid = 1'b1;
    wait_words("stall_pre", 2);
    bus.dst_ready = 8'h00;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_din_ready", {31'h0, bus.din_ready}, 32'h0);
      chk("stall_sel", {29'h0, bus.sel}, 32'h3);
      chk("stall_dout_valid", {24'h0, bus.dout_valid}, 32'h0);
      chk("stall_busy", {31'h0, bus.busy}, 32'h1);
    end
    chk("stall_no_done", bd_cnt - bd0, 0);
    bus.dst_ready = 8'h08;
    wait_words("stall_post", BURST);
    drain("stall");
    chk("stall_burst_done", bd_cnt - bd0, 1);

    // ---------------- abort by disabling d2 ----------------
    pulse_reset();
    plan_w.delete();
    add_burst(2, 1);
    add_burst(3, BURST);
    plan_start    = acc_cnt;
    bd0           = bd_cnt;
    strobe_or     = 8'h00;
    bus.en_mask   = 8'hFF;
    bus.dst_ready = 8'h04;
    bus.din_valid = 1'b1;
    wait_words("abort_pre", 1);
    bus.en_mask   = 8'hFB;
    bus.dst_ready = 8'hFF;
    wait_words("abort_post", 1 + BURST);
    drain("abort");
    chk("abort_strobes", {24'h0, strobe_or}, 32'h0C);
    chk("abort_burst_done", bd_cnt - bd0, 1);

    // ---------------- reset during a burst to d6 ----------------
    pulse_reset();
    plan_w.delete();
    add_burst(6, BURST);
    plan_start    = acc_cnt;
    bd0           = bd_cnt;
    bus.en_mask   = 8'hFF;
    bus.dst_ready = 8'h40;
    bus.din_valid = 1'b1;
    wait_words("midrst_pre", 2);
    rst = 1'b1;
    cyc(1);
    chk("midrst_sel", {29'h0, bus.sel}, 32'h0);
    chk("midrst_dout_valid", {24'h0, bus.dout_valid}, 32'h0);
    chk("midrst_dout", {24'h0, bus.dout}, 32'h0);
    chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
    chk("midrst_din_ready", {31'h0, bus.din_ready}, 32'h0);
    chk("midrst_queue_empty", exp_q.size(), 0);
    plan_w.delete();
    add_burst(0, BURST);
    plan_start    = acc_cnt;
    strobe_or     = 8'h00;
    bus.dst_ready = 8'hFF;
    rst = 1'b0;
    cyc(2);
    chk("midrst_regrant_sel", {29'h0, bus.sel}, 32'h0);
    chk("midrst_regrant_busy", {31'h0, bus.busy}, 32'h1);
    wait_words("midrst_post", BURST);
    drain("midrst");
    chk("midrst_strobes", {24'h0, strobe_or}, 32'h01);
    chk("midrst_burst_done", bd_cnt - bd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_burst_scheduler.md
Name: demux_burst_scheduler

Overview:
Controller that sequences the 1-to-8 demux. It accepts a word stream from a single source over a valid/ready handshake and steers it to one of 8 destinations in bursts of BURST words. Destinations are served in round-robin order, skipping any that are disabled or not ready. It drives the demux select lines and the one-hot output strobes, and sits between the upstream source and the demux fabric.

Parameters:
DW, 8, data word width
BURST, 4, words per destination before rotating (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
en_mask  input  8  per-destination enable; bit i enables destination i
din  input  DW  source data word
din_valid  input  1  source has a word
din_ready  output  1  scheduler accepts din this cycle (combinational)
dst_ready  input  8  destination i can take a word
sel  output  3  demux select {s2,s1,s0}; registered
dout  output  DW  steered data word; registered
dout_valid  output  8  one-hot write strobe, bit sel; registered
busy  output  1  high in SEND state
burst_done  output  1  one-cycle pulse when a full burst completes

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: sel=0, dout=0, dout_valid=0, busy=0, burst_done=0, rotation pointer ptr=0, burst counter cnt=0, state=IDLE. rst overrides everything, including mid-burst; an in-flight burst is discarded.
- States: IDLE, SEEK, SEND. din_ready is 0 in IDLE and SEEK.
- IDLE: go to SEEK when din_valid=1 and en_mask!=0. Otherwise stay.
- SEEK: candidate set c = en_mask & dst_ready.
  - Scan indices ptr, ptr+1, ... ptr+7 (mod 8). Pick the first set bit in one cycle.
  - If a bit is found: sel<=index, cnt<=0, go to SEND.
  - If c=0: stay in SEEK.
  - If din_valid=0 or en_mask=0: go to IDLE. This check has priority over the scan.
- SEND: busy=1. sel is held stable for the whole burst.
  - din_ready = dst_ready[sel] & en_mask[sel].
  - Transfer occurs when din_valid & din_ready. On a transfer: dout<=din, dout_valid<=(1<<sel), cnt<=cnt+1.
  - With no transfer, dout_valid<=0 and dout holds its value.
  - Latency: a word accepted in cycle N appears on dout/dout_valid in cycle N+1. dout_valid is never high for two destinations at once.
  - Burst end: a transfer with cnt==BURST-1 sets burst_done<=1 for one cycle, ptr<=sel+1 (7 wraps to 0), and goes to SEEK.
  - Abort: if en_mask[sel]=0 in SEND, go to SEEK with ptr<=sel+1 and no burst_done pulse. No transfer happens that cycle because din_ready is gated.
  - Stall: if dst_ready[sel]=0 or din_valid=0, stay in SEND; cnt and ptr hold. The scheduler does not rotate on a stall.
- Fairness: after any burst end or abort, the next grant searches starting from the index after the previous grant.
- BURST=1: every transfer completes a burst; burst_done pulses after each word.
- cnt width is 4 bits.

Test Plan:
- Reset: rst=1 for 2 cycles with din_valid=1 → sel=0, dout_valid=0, busy=0, din_ready=0. Release rst, en_mask=FF, dst_ready=FF → first grant sel=0 two cycles later.
- Round robin: en_mask=FF, dst_ready=FF, din_valid=1 continuous, din incrementing from 0x00, BURST=4.
  - Words 0x00-0x03 go to d0 with dout_valid=01.
  - Words 0x04-0x07 go to d1 with dout_valid=02.
  - This continues through d7, then wraps to d0.
  - burst_done pulses once per destination.
- Skip: en_mask=A5, dst_ready=FF → grant order is 0,2,5,7,0. Destinations 1,3,4,6 never strobe.
- Stall: in a burst to d3, drop dst_ready[3] for 5 cycles after 2 words.
  - din_ready=0 and sel=3 hold for the 5 cycles; no dout_valid.
  - On resume, 2 more words reach d3, then burst_done pulses.
- Abort: clear en_mask[2] after 1 word of a d2 burst.
  - No burst_done pulse.
  - Next grant is d3 (if enabled); d2 receives no further strobes.
- Mid-burst reset: assert rst during a SEND to d6 → next cycle all outputs are at reset values and ptr=0, so the first grant after release is d0.
